seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Session controller for serial pattern detection on the data_in bit stream.
- Holds a programmable pattern (1..PAT_W bits) written through a config port.
- Arms a detection window of N valid bits on start, then compares the stream against the pattern with overlap allowed.
- Counts matches, flags each one with a pulse, and reports done when the window closes.
- Software and testbenches use it to sequence and configure detection runs instead of hard-wiring a single fixed sequence.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 16, width of window length and match counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
cfg_we  input  1  config write strobe; sampled only in IDLE
cfg_pattern  input  PAT_W  pattern; bit [len-1] is compared against the oldest bit, bit 0 against the newest
cfg_len  input  $clog2(PAT_W+1)  pattern length, legal 1..PAT_W
cfg_window  input  CNT_W  number of valid bits per session, legal >=1
start  input  1  begin session; sampled only in IDLE
data_in  input  1  serial data bit
data_valid  input  1  data_in qualifier
busy  output  1  high in ARM and RUN
done  output  1  one-cycle pulse when the window closes
match_pulse  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  matches in the current or last session, saturating
err  output  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, shift/history/bit counters 0, config registers 0 (len=0, so a start with no prior config is rejected).
- States and transitions:
  - IDLE -> ARM on start when cfg regs are legal.
  - ARM -> RUN after exactly 1 cycle.
  - RUN -> DONE when the bit counter reaches window.
  - DONE -> IDLE after 1 cycle.
- IDLE:
  - cfg_we=1 latches pattern, len and window. cfg_we outside IDLE is ignored.
  - start=1 with len==0, len>PAT_W or window==0: err=1 for one cycle, stay IDLE.
  - Same-cycle cfg_we and start: the config is written first, and start is evaluated against the newly written values.
- ARM (1 cycle): clear shift register, history count, bit count and match_count. data_valid in ARM is ignored.
- RUN, on each cycle with data_valid=1:
  - shift <= {shift[PAT_W-2:0], data_in}
  - hist <= min(hist+1, len)
  - bits <= bits+1
  - A match occurs when the updated hist==len and the updated shift[len-1:0]==pattern[len-1:0].
  - On a match: match_pulse=1 on the following cycle (registered, latency 1 from the sampling edge), and match_count increments, saturating at 2^CNT_W-1.
  - Overlap is allowed: history is not cleared after a match.
- Cycles with data_valid=0 in RUN: no shift and no count; state holds indefinitely.
- RUN exit: when the updated bits==window, go to DONE on the same edge. A match on the final bit is still counted, and its match_pulse coincides with the DONE cycle.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- match_count holds its value in IDLE until the next accepted start clears it in ARM.
- start while busy or in DONE: ignored, no err.
- Reset asserted mid-session: immediate return to IDLE with all outputs 0. No done pulse is generated.
- busy is a registered decode of state (ARM|RUN).

Test Plan:
1. Reset, cfg pattern=8'b0000_1011, len=4, window=10; start; stream 1,0,1,1,0,1,1,0,0,0 (valid every cycle) -> match_pulse after bit 4 and bit 7, match_count=2, done one cycle after bit 10, busy drops the same cycle.
2. len=1, pattern=1, window=6, stream 1,1,1,0,1,1 -> match_count=5, five match_pulses.
3. Start with len=0 (post-reset) -> err=1 one cycle, busy stays 0. Then len=9 (PAT_W=8) -> err. Then window=0 -> err.
4. Gaps: pattern 3'b101, len=3, window=3, valid toggling 1,0,1,0,1 with data 1,x,0,x,1 -> one match, done only after the third valid bit.
5. Mid-RUN: assert rst_n=0 after 3 bits -> busy, done, match_pulse and match_count all 0 immediately. New start without cfg -> err. start and cfg_we pulsed during RUN -> no effect on the current session's result.
6. Saturation: CNT_W=4, pattern len=1 pattern=1, window=15 of all ones, rerun window with 20-bit stimulus impossible -> set window=15, expect match_count=15; rerun with overridden CNT_W=3, window=7, all ones -> match_count stays 7 (max).

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Session controller for serial pattern detection on a qualified bit stream.
// A pattern of 1..PAT_W bits and a window length are latched through a config
// port while idle. A start request arms a session. The session then shifts in
// each valid data bit and flags every occurrence of the pattern. Overlapping
// occurrences are counted. The session closes after `window` valid bits.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cfg_we       in   config write strobe (honoured in IDLE only)
//   cfg_pattern  in   pattern; bit [len-1] is the oldest bit, bit 0 the newest
//   cfg_len      in   pattern length, legal 1..PAT_W
//   cfg_window   in   valid bits per session, legal >= 1
//   start        in   begin a session (honoured in IDLE only)
//   data_in      in   serial data bit
//   data_valid   in   qualifier for data_in
//   busy         out  high while armed or running
//   done         out  one-cycle pulse when the window closes
//   match_pulse  out  one-cycle pulse per detected match
//   match_count  out  saturating match count of the current or last session
//   err          out  one-cycle pulse when a start is rejected
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter  int unsigned PAT_W = 8,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic             start,
  input  logic             data_in,
  input  logic             data_valid,
  output logic             busy,
  output logic             done,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q;

  // Configuration registers
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] win_q;

  // Session datapath
  logic [PAT_W-1:0] shift_q;
  logic [LEN_W-1:0] hist_q;
  logic [CNT_W-1:0] bits_q;
  logic [CNT_W-1:0] count_q;

  // Registered outputs
  logic             busy_q;
  logic             done_q;
  logic             match_q;
  logic             err_q;

  // Next-state values for the datapath, used on a valid RUN cycle
  logic [PAT_W-1:0] shift_d;
  logic [LEN_W-1:0] hist_d;
  logic [CNT_W-1:0] bits_d;
  logic [CNT_W-1:0] count_d;
  logic [PAT_W-1:0] len_mask;
  logic             hit;
  logic             win_end;

  // Config values that a start in this cycle is judged against. A write in the
  // same cycle takes effect first, so its values are the ones checked.
  logic [LEN_W-1:0] eff_len;
  logic [CNT_W-1:0] eff_win;
  logic             start_ok;

  always_comb begin
    eff_len  = cfg_we ? cfg_len    : len_q;
    eff_win  = cfg_we ? cfg_window : win_q;
    start_ok = (eff_len != '0) && (eff_len <= LEN_W'(PAT_W)) && (eff_win != '0);
  end

  always_comb begin
    shift_d = {shift_q[PAT_W-2:0], data_in};
    // History saturates at len. The compare happens before the increment, so
    // the sum cannot overflow LEN_W even when PAT_W+1 is a power of two.
    hist_d  = (hist_q >= len_q) ? len_q : hist_q + 1'b1;
    bits_d  = bits_q + 1'b1;
    count_d = (count_q == '1) ? count_q : count_q + 1'b1;

    len_mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      if (i < 32'(len_q)) begin
        len_mask[i] = 1'b1;
      end
    end

    // Only the low len bits take part in the compare. Pattern bits above len
    // are don't-care.
    hit     = (hist_d == len_q) && (((shift_d ^ pat_q) & len_mask) == '0);
    win_end = (bits_d == win_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      win_q   <= '0;
      shift_q <= '0;
      hist_q  <= '0;
      bits_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only for a single cycle.
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            win_q <= cfg_window;
          end
          if (start) begin
            if (start_ok) begin
              state_q <= ST_ARM;
              busy_q  <= 1'b1;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end

        ST_ARM: begin
          // data_valid is not looked at here; the session starts clean.
          shift_q <= '0;
          hist_q  <= '0;
          bits_q  <= '0;
          count_q <= '0;
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
        end

        ST_RUN: begin
          if (data_valid) begin
            shift_q <= shift_d;
            hist_q  <= hist_d;
            bits_q  <= bits_d;
            if (hit) begin
              match_q <= 1'b1;
              count_q <= count_d;
            end
            // The final bit's match pulse lands in the same cycle as done.
            if (win_end) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign match_pulse = match_q;
  assign match_count = count_q;
  assign err         = err_q;

endmodule
